// File: rtl/lpc_periph_multi_pkg.sv
// LPC field encodings, FSM state codes and small helpers shared by the
// lpc_periph_multi target and its address-window comparator.
package lpc_periph_multi_pkg;

    localparam logic [3:0] LPC_START      = 4'b0000;
    localparam logic [3:0] LPC_IO_READ    = 4'b0000;
    localparam logic [3:0] LPC_IO_WRITE   = 4'b0010;
    localparam logic [3:0] LPC_MEM_READ   = 4'b0100;
    localparam logic [3:0] LPC_MEM_WRITE  = 4'b0110;
    localparam logic [3:0] LPC_SYNC_READY = 4'b0000;
    localparam logic [3:0] LPC_SYNC_LWAIT = 4'b0110;
    localparam logic [3:0] LPC_SYNC_ERROR = 4'b1010;
    localparam logic [3:0] LPC_TAR_NIB    = 4'b1111;

    typedef enum logic [4:0] {
        LPC_MST_IDLE     = 5'd0,
        LPC_MST_START    = 5'd1,
        LPC_MST_CYCTYPE  = 5'd2,
        LPC_MST_ADDR     = 5'd3,
        LPC_MST_WDATA_LO = 5'd4,
        LPC_MST_WDATA_HI = 5'd5,
        LPC_MST_TAR1     = 5'd6,
        LPC_MST_TAR2     = 5'd7,
        LPC_MST_SYNC     = 5'd8,
        LPC_MST_RDATA_LO = 5'd9,
        LPC_MST_RDATA_HI = 5'd10,
        LPC_MST_FTAR     = 5'd11,
        LPC_MST_SKIP     = 5'd12
    } lpc_state_e;

    // Index of the final address nibble: 8 nibbles for memory, 4 for I/O.
    function automatic logic [2:0] last_addr_nib(input logic is_mem);
        return is_mem ? 3'd7 : 3'd3;
    endfunction

endpackage

// File: rtl/lpc_addr_window.sv
// Masked address-window comparator: hit when the masked address equals
// the masked base.
module lpc_addr_window #(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] BASE  = '0,
    parameter logic [WIDTH-1:0] MASK  = '1
) (
    input  logic [WIDTH-1:0] addr_i,
    output logic             hit_o
);

    assign hit_o = ((addr_i & MASK) == (BASE & MASK));

endmodule

// File: rtl/lpc_periph_multi.sv
// LPC peripheral target: decodes I/O and optional memory cycles against
// address windows and bridges them to a req/ack data provider.
module lpc_periph_multi
    import lpc_periph_multi_pkg::*;
#(
    parameter logic [15:0] IO_BASE  = 16'h0000,
    parameter logic [15:0] IO_MASK  = 16'hFFFF,
    parameter bit          MEM_EN   = 1'b0,
    parameter logic [31:0] MEM_BASE = 32'h0000_0000,
    parameter logic [31:0] MEM_MASK = 32'hFFFF_FFFF,
    parameter int unsigned MAX_WAIT = 64
) (
    input  logic        clk_i,
    input  logic        nrst_i,
    input  logic        lframe_i,
    inout  wire  [3:0]  lad_bus,
    output logic [31:0] lpc_addr_o,
    output logic        lpc_mem_o,
    output logic        lpc_we_o,
    output logic [7:0]  lpc_data_o,
    output logic        lpc_req_o,
    input  logic        lpc_ack_i,
    input  logic [7:0]  lpc_data_i,
    output logic        lpc_err_o,
    output logic [4:0]  fsm_state_export
);

    localparam logic [9:0] MAX_WAIT_C = 10'(MAX_WAIT);

    lpc_state_e  state_q, state_d;
    logic [2:0]  nib_cnt_q, nib_cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        mem_q, mem_d;
    logic        wr_q, wr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        req_q, req_d;
    logic        ack_seen_q, ack_seen_d;
    logic [9:0]  wait_cnt_q, wait_cnt_d;
    logic        err_q, err_d;
    logic        lad_oe_q, lad_oe_d;
    logic [3:0]  lad_q, lad_d;

    logic [3:0]  lad_in_s;
    logic [31:0] addr_shift_s;
    logic        io_hit_s, mem_hit_s, win_hit_s, ack_now_s, acked_s;

    assign lad_in_s     = lad_bus;
    assign addr_shift_s = {addr_q[27:0], lad_in_s};
    assign ack_now_s    = req_q & lpc_ack_i;
    assign acked_s      = ack_seen_q | ack_now_s;
    assign win_hit_s    = mem_q ? mem_hit_s : io_hit_s;

    lpc_addr_window #(.WIDTH(16), .BASE(IO_BASE), .MASK(IO_MASK)) u_io_win (
        .addr_i (addr_shift_s[15:0]),
        .hit_o  (io_hit_s)
    );

    lpc_addr_window #(.WIDTH(32), .BASE(MEM_BASE), .MASK(MEM_MASK)) u_mem_win (
        .addr_i (addr_shift_s),
        .hit_o  (mem_hit_s)
    );

    // Next-state logic for the cycle decoder, provider handshake and LAD driver.
    always_comb begin
        state_d    = state_q;
        nib_cnt_d  = nib_cnt_q;
        addr_d     = addr_q;
        mem_d      = mem_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        rdata_d    = ack_now_s ? lpc_data_i : rdata_q;
        req_d      = req_q & ~lpc_ack_i;
        ack_seen_d = ack_seen_q | ack_now_s;
        wait_cnt_d = wait_cnt_q;
        err_d      = 1'b0;
        lad_oe_d   = lad_oe_q;
        lad_d      = lad_q;

        if (!lframe_i) begin
            // LFRAME# low always aborts; only a 0000 nibble begins a new frame.
            state_d    = (lad_in_s == LPC_START) ? LPC_MST_START : LPC_MST_IDLE;
            req_d      = 1'b0;
            wait_cnt_d = 10'd0;
            lad_oe_d   = 1'b0;
        end else begin
            case (state_q)
                LPC_MST_IDLE: state_d = LPC_MST_IDLE;
                LPC_MST_START: begin
                    addr_d     = 32'h0000_0000;
                    nib_cnt_d  = 3'd0;
                    ack_seen_d = 1'b0;
                    case (lad_in_s)
                        LPC_IO_READ, LPC_IO_WRITE: begin
                            mem_d   = 1'b0;
                            wr_d    = lad_in_s[1];
                            state_d = LPC_MST_CYCTYPE;
                        end
                        LPC_MEM_READ, LPC_MEM_WRITE: begin
                            mem_d   = MEM_EN;
                            wr_d    = lad_in_s[1];
                            state_d = MEM_EN ? LPC_MST_CYCTYPE : LPC_MST_IDLE;
                        end
                        default: state_d = LPC_MST_IDLE;
                    endcase
                end
                LPC_MST_CYCTYPE: begin
                    addr_d    = addr_shift_s;
                    nib_cnt_d = 3'd1;
                    state_d   = LPC_MST_ADDR;
                end
                LPC_MST_ADDR: begin
                    addr_d    = addr_shift_s;
                    nib_cnt_d = nib_cnt_q + 3'd1;
                    if (nib_cnt_q == last_addr_nib(mem_q)) begin
                        if (!win_hit_s) begin
                            state_d = LPC_MST_SKIP;
                        end else if (wr_q) begin
                            state_d = LPC_MST_WDATA_LO;
                        end else begin
                            req_d   = 1'b1;
                            state_d = LPC_MST_TAR1;
                        end
                    end else begin
                        state_d = LPC_MST_ADDR;
                    end
                end
                LPC_MST_WDATA_LO: begin
                    wdata_d[3:0] = lad_in_s;
                    state_d      = LPC_MST_WDATA_HI;
                end
                LPC_MST_WDATA_HI: begin
                    wdata_d[7:4] = lad_in_s;
                    req_d        = 1'b1;
                    state_d      = LPC_MST_TAR1;
                end
                LPC_MST_TAR1: state_d = LPC_MST_TAR2;
                LPC_MST_TAR2: begin
                    lad_oe_d   = 1'b1;
                    lad_d      = acked_s ? LPC_SYNC_READY : LPC_SYNC_LWAIT;
                    wait_cnt_d = acked_s ? 10'd0 : 10'd1;
                    state_d    = LPC_MST_SYNC;
                end
                LPC_MST_SYNC: begin
                    // A non-LWAIT nibble on the bus means the final SYNC was just sent.
                    if (lad_q != LPC_SYNC_LWAIT) begin
                        lad_d   = wr_q ? LPC_TAR_NIB : rdata_q[3:0];
                        state_d = wr_q ? LPC_MST_FTAR : LPC_MST_RDATA_LO;
                    end else if (acked_s) begin
                        lad_d = LPC_SYNC_READY;
                    end else if (wait_cnt_q >= MAX_WAIT_C) begin
                        lad_d   = LPC_SYNC_ERROR;
                        err_d   = 1'b1;
                        req_d   = 1'b0;
                        rdata_d = 8'hFF;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 10'd1;
                    end
                end
                LPC_MST_RDATA_LO: begin
                    lad_d   = rdata_q[7:4];
                    state_d = LPC_MST_RDATA_HI;
                end
                LPC_MST_RDATA_HI: begin
                    lad_d   = LPC_TAR_NIB;
                    state_d = LPC_MST_FTAR;
                end
                LPC_MST_FTAR: begin
                    lad_oe_d = 1'b0;
                    state_d  = LPC_MST_IDLE;
                end
                LPC_MST_SKIP: state_d = LPC_MST_SKIP;
                default: begin
                    lad_oe_d = 1'b0;
                    state_d  = LPC_MST_IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q    <= LPC_MST_IDLE;
            nib_cnt_q  <= 3'd0;
            addr_q     <= 32'h0000_0000;
            mem_q      <= 1'b0;
            wr_q       <= 1'b0;
            wdata_q    <= 8'h00;
            rdata_q    <= 8'h00;
            req_q      <= 1'b0;
            ack_seen_q <= 1'b0;
            wait_cnt_q <= 10'd0;
            err_q      <= 1'b0;
            lad_oe_q   <= 1'b0;
            lad_q      <= 4'h0;
        end else begin
            state_q    <= state_d;
            nib_cnt_q  <= nib_cnt_d;
            addr_q     <= addr_d;
            mem_q      <= mem_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            req_q      <= req_d;
            ack_seen_q <= ack_seen_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
            lad_oe_q   <= lad_oe_d;
            lad_q      <= lad_d;
        end
    end

    assign lad_bus          = lad_oe_q ? lad_q : 4'bzzzz;
    assign lpc_addr_o       = addr_q;
    assign lpc_mem_o        = mem_q;
    assign lpc_we_o         = wr_q;
    assign lpc_data_o       = wdata_q;
    assign lpc_req_o        = req_q;
    assign lpc_err_o        = err_q;
    assign fsm_state_export = state_q;

endmodule

// File: tb/tb_lpc_periph_multi.sv
// Randomized self-checking bench for lpc_periph_multi: a host/provider driver
// and a transaction-level model of the expected LAD/SYNC/data sequence.
module tb_lpc_periph_multi;
    import lpc_periph_multi_pkg::*;

    localparam logic [15:0] IO_BASE  = 16'h0060;
    localparam logic [15:0] IO_MASK  = 16'hFFF0;
    localparam logic [31:0] MEM_BASE = 32'hFED4_0000;
    localparam logic [31:0] MEM_MASK = 32'hFFFF_0000;
    localparam int          MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        lframe = 1'b1;
    logic        ack = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        host_oe = 1'b0;
    logic [3:0]  host_nib = 4'h0;
    tri1  [3:0]  lad;
    logic [31:0] addr_o;
    logic        mem_o, we_o, req_o, err_o;
    logic [7:0]  data_o;
    logic [4:0]  state_o;

    int n_checks = 0;
    int n_fail   = 0;

    assign lad = host_oe ? host_nib : 4'bzzzz;

    always #5 clk = ~clk;

    lpc_periph_multi #(
        .IO_BASE(IO_BASE), .IO_MASK(IO_MASK), .MEM_EN(1'b1),
        .MEM_BASE(MEM_BASE), .MEM_MASK(MEM_MASK), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk_i(clk), .nrst_i(nrst), .lframe_i(lframe), .lad_bus(lad),
        .lpc_addr_o(addr_o), .lpc_mem_o(mem_o), .lpc_we_o(we_o),
        .lpc_data_o(data_o), .lpc_req_o(req_o), .lpc_ack_i(ack),
        .lpc_data_i(din), .lpc_err_o(err_o), .fsm_state_export(state_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One bus cycle: inputs are applied just after the rising edge, outputs read then.
    task automatic step(input logic lf, input logic hoe, input logic [3:0] nib, input logic a);
        @(posedge clk);
        #1;
        lframe   = lf;
        host_oe  = hoe;
        host_nib = nib;
        ack      = a;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "/lad"},   32'(lad),     32'hF);
        check_eq({tag, "/req"},   32'(req_o),   32'h0);
        check_eq({tag, "/err"},   32'(err_o),   32'h0);
        check_eq({tag, "/we"},    32'(we_o),    32'h0);
        check_eq({tag, "/mem"},   32'(mem_o),   32'h0);
        check_eq({tag, "/addr"},  addr_o,       32'h0);
        check_eq({tag, "/data"},  32'(data_o),  32'h0);
        check_eq({tag, "/state"}, 32'(state_o), 32'(LPC_MST_IDLE));
    endtask

    // k = cycles from the request-rise cycle to the ack pulse (-1: no ack);
    // cut >= 0 returns right after that post-address cycle has been checked.
    task automatic run_txn(input logic is_mem, input logic is_wr, input logic [31:0] addr,
                           input logic [7:0] wdat, input logic [7:0] rdat,
                           input int k, input int cut, input string tag);
        logic [3:0]  cyc, exp_lad;
        logic [31:0] sh, exp_addr;
        logic [7:0]  rd;
        logic        hit, err, exp_req, exp_err;
        int          nn, nw, req_end;
        logic [3:0]  expq[$];

        cyc = is_mem ? (is_wr ? 4'b0110 : 4'b0100) : (is_wr ? 4'b0010 : 4'b0000);
        nn  = is_mem ? 8 : 4;
        hit = is_mem ? ((addr & MEM_MASK) == (MEM_BASE & MEM_MASK))
                     : ((addr[15:0] & IO_MASK) == (IO_BASE & IO_MASK));
        exp_addr = is_mem ? addr : {16'h0000, addr[15:0]};

        // Sync phase: one LWAIT per cycle the ack is still missing after TAR, capped.
        if (k < 0) begin
            err = 1'b1;
            nw  = MAX_WAIT;
        end else begin
            nw  = (k <= 1) ? 0 : k - 1;
            err = (nw > MAX_WAIT);
            if (err) nw = MAX_WAIT;
        end
        req_end = err ? MAX_WAIT + 1 : k;
        expq = {};
        if (hit) begin
            repeat (nw) expq.push_back(4'b0110);
            expq.push_back(err ? 4'b1010 : 4'b0000);
            if (!is_wr) begin
                rd = err ? 8'hFF : rdat;
                expq.push_back(rd[3:0]);
                expq.push_back(rd[7:4]);
            end
            expq.push_back(4'hF);
        end

        step(1'b0, 1'b1, 4'h0, 1'b0);
        step(1'b1, 1'b1, cyc, 1'b0);
        for (int i = nn - 1; i >= 0; i--) begin
            sh = addr >> (4 * i);
            step(1'b1, 1'b1, sh[3:0], 1'b0);
        end
        if (is_wr) begin
            step(1'b1, 1'b1, wdat[3:0], 1'b0);
            step(1'b1, 1'b1, wdat[7:4], 1'b0);
        end
        din = rdat;
        for (int j = 0; j < 16; j++) begin
            step(1'b1, (j == 0), 4'hF, (j == k));
            exp_req = hit && (j <= req_end);
            exp_err = hit && err && (j == MAX_WAIT + 2);
            check_eq({tag, "/req"}, 32'(req_o), 32'(exp_req));
            check_eq({tag, "/err"}, 32'(err_o), 32'(exp_err));
            if (j == 0) begin
                check_eq({tag, "/addr"}, addr_o, exp_addr);
                check_eq({tag, "/mem"}, 32'(mem_o), 32'(is_mem));
                if (hit) check_eq({tag, "/we"}, 32'(we_o), 32'(is_wr));
            end else begin
                if (j >= 2 && (j - 2) < expq.size()) exp_lad = expq[j - 2];
                else exp_lad = 4'hF;
                check_eq({tag, "/lad"}, 32'(lad), 32'(exp_lad));
            end
            if (j == cut) return;
        end
        if (hit && is_wr) check_eq({tag, "/wdata"}, 32'(data_o), 32'(wdat));
    endtask

    initial begin
        logic        r_mem, r_wr, r_hit;
        logic [31:0] r_addr;
        int          r_k;

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        nrst = 1'b1;

        run_txn(1'b0, 1'b0, 32'h0060, 8'h00, 8'hA5, 0, -1, "io_rd");
        run_txn(1'b0, 1'b1, 32'h0064, 8'h3C, 8'h00, 3, -1, "io_wr");
        run_txn(1'b1, 1'b0, 32'hFED4_0000, 8'h00, 8'h42, 1, -1, "mem_rd");
        run_txn(1'b1, 1'b0, 32'hFED5_0000, 8'h00, 8'h42, 0, -1, "mem_miss");
        run_txn(1'b0, 1'b0, 32'h0070, 8'h00, 8'h11, 0, -1, "io_miss");
        run_txn(1'b0, 1'b0, 32'h0060, 8'h00, 8'h99, -1, -1, "timeout");
        run_txn(1'b0, 1'b0, 32'h0061, 8'h00, 8'hC3, 5, -1, "last_wait");
        run_txn(1'b0, 1'b1, 32'h006F, 8'h7E, 8'h00, 6, -1, "late_ack");

        // Abort during the second LWAIT, then a back-to-back read.
        run_txn(1'b0, 1'b0, 32'h0060, 8'h00, 8'h00, -1, 3, "abort");
        lframe = 1'b0;
        step(1'b1, 1'b0, 4'h0, 1'b0);
        check_eq("abort/lad_release", 32'(lad), 32'hF);
        check_eq("abort/req_drop", 32'(req_o), 32'h0);
        run_txn(1'b0, 1'b0, 32'h0062, 8'h00, 8'h5A, 2, -1, "after_abort");

        // Asynchronous reset in the middle of a waiting memory write.
        run_txn(1'b1, 1'b1, 32'hFED4_0010, 8'h5A, 8'h00, -1, 3, "pre_rst");
        #2 nrst = 1'b0;
        #1 check_reset_values("mid_rst");
        @(negedge clk);
        nrst = 1'b1;
        run_txn(1'b0, 1'b0, 32'h0060, 8'h00, 8'h3D, 0, -1, "post_rst");

        for (int t = 0; t < 40; t++) begin
            r_mem = 1'($urandom_range(0, 1));
            r_wr  = 1'($urandom_range(0, 1));
            r_hit = ($urandom_range(0, 3) != 0);
            if (r_mem) r_addr = r_hit ? {MEM_BASE[31:16], 16'($urandom)} : $urandom;
            else       r_addr = r_hit ? {16'h0000, IO_BASE[15:4], 4'($urandom)} : {16'h0000, 16'($urandom)};
            r_k = int'($urandom_range(0, 7)) - 1;
            run_txn(r_mem, r_wr, r_addr, 8'($urandom), 8'($urandom), r_k, -1, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
